// File: rtl/conv_mem_write_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_mem_write_gen                                                       |
// | Per-channel output feature-map write-address generator with start/busy/  |
// | done handshake, programmable start delay and enable-based stalling.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_mem_write_gen #(
   parameter int ADDR_W         = 10,
   parameter int NUM_CH         = 2,
   parameter int CH_STRIDE      = 144,
   parameter int CYCLES_PER_PIX = 25,
   parameter int START_DELAY    = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     enable,
   output logic [NUM_CH*ADDR_W-1:0] addr,
   output logic                     we,
   output logic                     busy,
   output logic                     done
);

   localparam int c_cyc_w = (CYCLES_PER_PIX > 1) ? $clog2(CYCLES_PER_PIX) : 1;
   localparam int c_pix_w = (CH_STRIDE > 1) ? $clog2(CH_STRIDE) : 1;
   localparam int c_dly_w = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

   localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(CYCLES_PER_PIX - 1);
   localparam logic [c_pix_w-1:0] c_pix_last = c_pix_w'(CH_STRIDE - 1);
   localparam logic [c_dly_w-1:0] c_dly_last = c_dly_w'((START_DELAY > 0) ? START_DELAY - 1 : 0);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_delay = 2'd1;
   localparam logic [1:0] c_st_run   = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   if (ADDR_W < 1 || ADDR_W > 32) begin : g_chk_addr_w
      $error("conv_mem_write_gen: ADDR_W must be in 1..32");
   end
   if (NUM_CH < 1) begin : g_chk_num_ch
      $error("conv_mem_write_gen: NUM_CH must be >= 1");
   end
   if (CH_STRIDE < 1) begin : g_chk_stride
      $error("conv_mem_write_gen: CH_STRIDE must be >= 1");
   end
   if (CYCLES_PER_PIX < 1) begin : g_chk_cpp
      $error("conv_mem_write_gen: CYCLES_PER_PIX must be >= 1");
   end
   if (START_DELAY < 0) begin : g_chk_delay
      $error("conv_mem_write_gen: START_DELAY must be >= 0");
   end
   if ((64'(NUM_CH) * 64'(CH_STRIDE)) > (64'd1 << ADDR_W)) begin : g_chk_fit
      $error("conv_mem_write_gen: NUM_CH*CH_STRIDE exceeds the address space");
   end

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_cyc_w-1:0] r_cyc;
   logic [c_pix_w-1:0] r_pix;
   logic [c_dly_w-1:0] r_dly;
   logic               w_load;
   logic               w_step;
   logic               w_last_pix;

   assign w_load     = ((r_state == c_st_idle) || (r_state == c_st_done)) && start;
   assign w_last_pix = (r_pix == c_pix_last);
   assign w_step     = we && !w_last_pix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle, c_st_done: begin
            if (start) begin
               w_state_nxt = (START_DELAY == 0) ? c_st_run : c_st_delay;
            end
         end
         c_st_delay: begin
            if (enable && (r_dly == c_dly_last)) begin
               w_state_nxt = c_st_run;
            end
         end
         c_st_run: begin
            if (we && w_last_pix) begin
               w_state_nxt = c_st_done;
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      we   = (r_state == c_st_run) && enable && (r_cyc == c_cyc_last);
      busy = (r_state == c_st_delay) || (r_state == c_st_run);
      done = (r_state == c_st_done);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cyc <= '0;
         r_pix <= '0;
         r_dly <= '0;
      end else if (w_load) begin
         r_cyc <= '0;
         r_pix <= '0;
         r_dly <= '0;
      end else begin
         if ((r_state == c_st_delay) && enable) begin
            r_dly <= r_dly + c_dly_w'(1);
         end
         if ((r_state == c_st_run) && enable) begin
            if (we) begin
               r_cyc <= '0;
               if (!w_last_pix) begin
                  r_pix <= r_pix + c_pix_w'(1);
               end
            end else begin
               r_cyc <= r_cyc + c_cyc_w'(1);
            end
         end
      end
   end

   // The final pixel leaves each lane at its last address, which DONE then holds.
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
      localparam logic [ADDR_W-1:0] c_base = ADDR_W'(ch * CH_STRIDE);
      logic [ADDR_W-1:0] r_lane;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_lane <= c_base;
         end else if (w_load) begin
            r_lane <= c_base;
         end else if (w_step) begin
            r_lane <= r_lane + ADDR_W'(1);
         end
      end

      assign addr[ch*ADDR_W +: ADDR_W] = r_lane;
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_write_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_mem_write_gen                                                    |
// | Directed bench: default two-channel instance plus a four-lane variant.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_conv_mem_write_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, enable;
   logic [19:0] addr;
   logic        we, busy, done;
   logic        start2, enable2;
   logic [15:0] addr2;
   logic        we2, busy2, done2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_mem_write_gen dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .enable (enable),
      .addr   (addr),
      .we     (we),
      .busy   (busy),
      .done   (done)
   );

   conv_mem_write_gen #(
      .ADDR_W         (4),
      .NUM_CH         (4),
      .CH_STRIDE      (4),
      .CYCLES_PER_PIX (1),
      .START_DELAY    (0)
   ) dut_var (
      .clk    (clk),
      .reset  (reset),
      .start  (start2),
      .enable (enable2),
      .addr   (addr2),
      .we     (we2),
      .busy   (busy2),
      .done   (done2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one pass from IDLE/DONE and records the event cycles relative to the start cycle.
   task automatic watch_pass(input string name, input int stall_lo, input int stall_hi,
                             input int pulse_a, input int pulse_b,
                             input int exp_first, input int exp_second,
                             input int exp_last, input int exp_done);
      int first_c = -1, second_c = -1, last_c = -1, done_c = -1;
      int nwe = 0, we_stalled = 0, overlap = 0;
      logic [9:0] f0 = '0, f1 = '0, s0 = '0, s1 = '0, l0 = '0, l1 = '0;
      start  = 1'b1;
      enable = 1'b1;
      tick();
      start  = 1'b0;
      #1;
      check({name, "_c1_busy"}, 32'(busy), 32'd1);
      check({name, "_c1_done"}, 32'(done), 32'd0);
      check({name, "_c1_lanes"}, {12'd0, addr}, {12'd0, 10'd144, 10'd0});
      for (int c = 1; c < 4000; c++) begin
         enable = !((c >= stall_lo) && (c <= stall_hi));
         start  = (c == pulse_a) || (c == pulse_b);
         #1;
         if (busy && done) overlap++;
         if (we) begin
            nwe++;
            if (!enable) we_stalled++;
            if (first_c < 0) begin
               first_c = c; f0 = addr[9:0]; f1 = addr[19:10];
            end else if (second_c < 0) begin
               second_c = c; s0 = addr[9:0]; s1 = addr[19:10];
            end
            last_c = c; l0 = addr[9:0]; l1 = addr[19:10];
         end
         if (done) begin
            done_c = c;
            break;
         end
         tick();
      end
      start  = 1'b0;
      enable = 1'b1;
      check({name, "_first_cyc"}, first_c, exp_first);
      check({name, "_first_lanes"}, {12'd0, f1, f0}, {12'd0, 10'd144, 10'd0});
      check({name, "_second_cyc"}, second_c, exp_second);
      check({name, "_second_lanes"}, {12'd0, s1, s0}, {12'd0, 10'd145, 10'd1});
      check({name, "_last_cyc"}, last_c, exp_last);
      check({name, "_last_lanes"}, {12'd0, l1, l0}, {12'd0, 10'd287, 10'd143});
      check({name, "_done_cyc"}, done_c, exp_done);
      check({name, "_num_we"}, nwe, 144);
      check({name, "_we_stalled"}, we_stalled, 0);
      check({name, "_busy_done_overlap"}, overlap, 0);
      repeat (3) tick();
      check({name, "_done_hold"}, {29'd0, done, busy, we}, 32'b100);
      check({name, "_done_lanes"}, {12'd0, addr}, {12'd0, 10'd287, 10'd143});
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      enable  = 1'b0;
      start2  = 1'b0;
      enable2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_lanes", {12'd0, addr}, {12'd0, 10'd144, 10'd0});
      check("rst_flags", {29'd0, we, busy, done}, 32'd0);
      check("rst_var_lanes", {16'd0, addr2}, 32'h0000_C840);
      check("rst_var_flags", {29'd0, we2, busy2, done2}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Four-lane single-cycle variant with no start delay.
      start2  = 1'b1;
      enable2 = 1'b1;
      tick();
      start2 = 1'b0;
      #1;
      check("var_c1_we", 32'(we2), 32'd1);
      check("var_c1_lanes", {16'd0, addr2}, 32'h0000_C840);
      tick();
      check("var_c2_we", 32'(we2), 32'd1);
      tick();
      check("var_c3_we", 32'(we2), 32'd1);
      tick();
      check("var_c4_we", 32'(we2), 32'd1);
      check("var_c4_lanes", {16'd0, addr2}, 32'h0000_FB73);
      tick();
      check("var_c5_done", {29'd0, done2, busy2, we2}, 32'b100);
      check("var_c5_lanes", {16'd0, addr2}, 32'h0000_FB73);

      watch_pass("dflt", -1, -1, -1, -1, 26, 51, 3601, 3602);
      watch_pass("stall", 10, 14, -1, -1, 31, 56, 3606, 3607);

      // Abort a pass at cycle 1000 with an asynchronous reset.
      start  = 1'b1;
      enable = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 1000; c++) tick();
      check("mid_busy_before_reset", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_flags", {29'd0, we, busy, done}, 32'd0);
      check("mid_rst_lanes", {12'd0, addr}, {12'd0, 10'd144, 10'd0});
      @(negedge clk);
      reset = 1'b0;
      tick();
      watch_pass("after_rst", -1, -1, -1, -1, 26, 51, 3601, 3602);

      // Restart from DONE with ignored start pulses during RUN.
      watch_pass("restart", -1, -1, 300, 2000, 26, 51, 3601, 3602);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
